// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the grid tracker: raw levels in,
// debounced levels, move pulses and overrun flag out.
interface button_conditioner_if #(
  parameter int unsigned NBTN = 3
);
  logic [NBTN-1:0] PushButton;
  logic [NBTN-1:0] BtnLevel;
  logic [NBTN-1:0] BtnPulse;
  logic            Overrun;

  modport master (output PushButton, input BtnLevel, BtnPulse, Overrun);
  modport slave  (input PushButton, output BtnLevel, BtnPulse, Overrun);
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, per-channel debounce and
// auto-repeat, and a lowest-index-first one-hot pulse arbiter with a gap cycle.
module button_conditioner #(
  parameter int unsigned NBTN            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_RATE     = 8
) (
  input logic                 CLK,
  input logic                 RESET,
  button_conditioner_if.slave btn
);
  localparam int unsigned   CW         = 32;
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RPT_DELAY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DELAY - REPEAT_RATE);
  localparam bit            RPT_EN     = (REPEAT_DELAY != 0);

  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [NBTN-1:0] level_q, level_d;
  logic [NBTN-1:0] pend_q, pend_d;
  logic [NBTN-1:0] pulse_q, pulse_d;
  logic            overrun_q, overrun_d;
  logic [CW-1:0]   dc_q [NBTN];
  logic [CW-1:0]   dc_d [NBTN];
  logic [CW-1:0]   rc_q [NBTN];
  logic [CW-1:0]   rc_d [NBTN];
  logic [NBTN-1:0] event_c;
  logic [NBTN-1:0] grant_c;
  logic            granted_c;

  always_comb begin
    level_d   = level_q;
    event_c   = '0;
    grant_c   = '0;
    granted_c = 1'b0;
    for (int i = 0; i < int'(NBTN); i++) begin
      dc_d[i] = dc_q[i];
      rc_d[i] = rc_q[i];
    end

    // Debounce: level follows the synchronized input only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    for (int i = 0; i < int'(NBTN); i++) begin
      if (sync2_q[i] == level_q[i]) begin
        dc_d[i] = '0;
      end else if (dc_q[i] == DEB_LAST) begin
        level_d[i] = sync2_q[i];
        dc_d[i]    = '0;
      end else begin
        dc_d[i] = dc_q[i] + CW'(1);
      end
    end

    // Press on rising level; repeats while held, first after the delay then at the rate.
    for (int i = 0; i < int'(NBTN); i++) begin
      if (level_d[i] && !level_q[i]) begin
        event_c[i] = 1'b1;
        rc_d[i]    = '0;
      end else if (!level_d[i]) begin
        rc_d[i] = '0;
      end else if (RPT_EN && ((rc_q[i] + CW'(1)) == RPT_DELAY)) begin
        event_c[i] = 1'b1;
        rc_d[i]    = RPT_RELOAD;
      end else begin
        rc_d[i] = rc_q[i] + CW'(1);
      end
    end

    // A pulse is always followed by an idle cycle so every pulse is a fresh edge.
    if (pulse_q == '0) begin
      for (int i = 0; i < int'(NBTN); i++) begin
        if (pend_q[i] && !granted_c) begin
          grant_c[i] = 1'b1;
          granted_c  = 1'b1;
        end
      end
    end

    pulse_d   = grant_c;
    pend_d    = (pend_q & ~grant_c) | event_c;
    overrun_d = overrun_q | (|(event_c & pend_q & ~grant_c));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pend_q    <= '0;
      pulse_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < int'(NBTN); i++) begin
        dc_q[i] <= '0;
        rc_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn.PushButton;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pend_q    <= pend_d;
      pulse_q   <= pulse_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < int'(NBTN); i++) begin
        dc_q[i] <= dc_d[i];
        rc_q[i] <= rc_d[i];
      end
    end
  end

  assign btn.BtnLevel = level_q;
  assign btn.BtnPulse = pulse_q;
  assign btn.Overrun  = overrun_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a default-rate instance and a fast-repeat
// instance share the same buttons and are checked against a timing model.
module tb_button_conditioner;
  localparam int NBTN   = 3;
  localparam int DEB    = 4;
  localparam int DLY    = 20;
  localparam int RATE_A = 8;
  localparam int RATE_B = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] pb;
  int         cyc;
  int         checks;
  int         passed;

  button_conditioner_if #(.NBTN(NBTN)) if_a ();
  button_conditioner_if #(.NBTN(NBTN)) if_b ();
  assign if_a.PushButton = pb;
  assign if_b.PushButton = pb;

  button_conditioner #(.NBTN(NBTN), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY),
                       .REPEAT_RATE(RATE_A)) dut_a (.CLK(CLK), .RESET(RESET), .btn(if_a));
  button_conditioner #(.NBTN(NBTN), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY),
                       .REPEAT_RATE(RATE_B)) dut_b (.CLK(CLK), .RESET(RESET), .btn(if_b));

  always #5 CLK = ~CLK;

  logic [6:0] obs [2];
  assign obs[0] = {if_a.BtnLevel, if_a.BtnPulse, if_a.Overrun};
  assign obs[1] = {if_b.BtnLevel, if_b.BtnPulse, if_b.Overrun};

  // Model: input history, time-in-disagreement, time-held, pending set.
  int         rate_m [2] = '{RATE_A, RATE_B};
  logic [2:0] m_st1 [2];
  logic [2:0] m_st2 [2];
  logic [2:0] m_lvl [2];
  logic [2:0] m_pend [2];
  logic [2:0] m_pulse [2];
  logic       m_ovr [2];
  int         m_run [2][3];
  int         m_hold [2][3];

  task automatic model_step();
    logic [2:0] lvl_new, ev, clr;
    bit picked;
    for (int m = 0; m < 2; m++) begin
      if (RESET) begin
        m_st1[m] = '0; m_st2[m] = '0; m_lvl[m] = '0;
        m_pend[m] = '0; m_pulse[m] = '0; m_ovr[m] = 1'b0;
        for (int i = 0; i < 3; i++) begin
          m_run[m][i] = 0;
          m_hold[m][i] = 0;
        end
      end else begin
        lvl_new = m_lvl[m];
        ev = '0;
        clr = '0;
        for (int i = 0; i < 3; i++) begin
          if (m_st2[m][i] == m_lvl[m][i]) m_run[m][i] = 0;
          else begin
            m_run[m][i]++;
            if (m_run[m][i] == DEB) begin
              lvl_new[i] = m_st2[m][i];
              m_run[m][i] = 0;
            end
          end
          if (lvl_new[i] && !m_lvl[m][i]) begin
            m_hold[m][i] = 0;
            ev[i] = 1'b1;
          end else if (!lvl_new[i]) begin
            m_hold[m][i] = 0;
          end else begin
            m_hold[m][i]++;
            if (DLY != 0 && m_hold[m][i] >= DLY && ((m_hold[m][i] - DLY) % rate_m[m]) == 0)
              ev[i] = 1'b1;
          end
        end
        picked = 1'b0;
        if (m_pulse[m] == 3'b000) begin
          for (int i = 0; i < 3; i++)
            if (m_pend[m][i] && !picked) begin
              clr[i] = 1'b1;
              picked = 1'b1;
            end
        end
        m_ovr[m]   = m_ovr[m] | (|(ev & m_pend[m] & ~clr));
        m_pend[m]  = (m_pend[m] & ~clr) | ev;
        m_pulse[m] = clr;
        m_lvl[m]   = lvl_new;
        m_st2[m]   = m_st1[m];
        m_st1[m]   = pb;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    pb = '0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      RESET = (c < 3);
      pb = (c < 3) ? 3'($urandom) : 3'b000;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== 7'd0)
          $display("FAIL reset_zero inst%0d cyc=%0d got=%b expected=%b", m, cyc, obs[m], 7'd0);
        else passed++;
      end
    end
  endtask

  task automatic test_single_press();
    int e, pulses, first, lvl_cnt;
    do_reset();
    e = cyc + 1; pulses = 0; first = -1; lvl_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      pb = (c < 10) ? 3'b001 : 3'b000;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== {m_lvl[m], m_pulse[m], m_ovr[m]})
          $display("FAIL single_model inst%0d cyc=%0d got=%b expected=%b", m, cyc, obs[m], {m_lvl[m], m_pulse[m], m_ovr[m]});
        else passed++;
      end
      if (if_a.BtnPulse[0]) begin
        pulses++;
        if (first < 0) first = cyc - e;
      end
      if (if_a.BtnLevel[0]) lvl_cnt++;
    end
    checks++;
    if (pulses !== 1) $display("FAIL single_count got=%0d expected=1", pulses); else passed++;
    checks++;
    if (first !== 6) $display("FAIL single_latency got=%0d expected=6", first); else passed++;
    checks++;
    if (lvl_cnt !== 10) $display("FAIL single_level_len got=%0d expected=10", lvl_cnt); else passed++;
  endtask

  task automatic test_bounce();
    int e, pulses, first;
    do_reset();
    e = cyc + 1; pulses = 0; first = -1;
    for (int c = 0; c < 50; c++) begin
      if (c < 12) pb = (c % 2 == 0) ? 3'b010 : 3'b000;
      else pb = (c < 25) ? 3'b010 : 3'b000;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== {m_lvl[m], m_pulse[m], m_ovr[m]})
          $display("FAIL bounce_model inst%0d cyc=%0d got=%b expected=%b", m, cyc, obs[m], {m_lvl[m], m_pulse[m], m_ovr[m]});
        else passed++;
      end
      if (if_a.BtnPulse[1]) begin
        pulses++;
        if (first < 0) first = cyc - e;
      end
    end
    checks++;
    if (pulses !== 1) $display("FAIL bounce_count got=%0d expected=1", pulses); else passed++;
    checks++;
    if (first !== 18) $display("FAIL bounce_latency got=%0d expected=18", first); else passed++;
  endtask

  task automatic test_auto_repeat();
    int e;
    int offs[$];
    int exp_off [6] = '{0, 20, 28, 36, 44, 52};
    do_reset();
    e = cyc + 1;
    for (int c = 0; c < 90; c++) begin
      pb = (c < 60) ? 3'b100 : 3'b000;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== {m_lvl[m], m_pulse[m], m_ovr[m]})
          $display("FAIL repeat_model inst%0d cyc=%0d got=%b expected=%b", m, cyc, obs[m], {m_lvl[m], m_pulse[m], m_ovr[m]});
        else passed++;
      end
      if (if_a.BtnPulse[2]) offs.push_back(cyc - (e + 6));
    end
    checks++;
    if (offs.size() !== 6) $display("FAIL repeat_count got=%0d expected=6", offs.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      if (i < offs.size()) begin
        checks++;
        if (offs[i] !== exp_off[i])
          $display("FAIL repeat_offset idx=%0d got=%0d expected=%0d", i, offs[i], exp_off[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_simultaneous();
    int e, ovr_seen;
    logic [2:0] got_seq [5];
    logic [2:0] exp_seq [5] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
    do_reset();
    e = cyc + 1; ovr_seen = 0;
    for (int k = 0; k < 5; k++) got_seq[k] = 3'b111;
    for (int c = 0; c < 30; c++) begin
      pb = (c < 10) ? 3'b111 : 3'b000;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== {m_lvl[m], m_pulse[m], m_ovr[m]})
          $display("FAIL simul_model inst%0d cyc=%0d got=%b expected=%b", m, cyc, obs[m], {m_lvl[m], m_pulse[m], m_ovr[m]});
        else passed++;
      end
      if (cyc - e >= 6 && cyc - e <= 10) got_seq[cyc - e - 6] = if_a.BtnPulse;
      if (if_a.Overrun !== 1'b0) ovr_seen++;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_seq[k] !== exp_seq[k])
        $display("FAIL simul_order slot=%0d got=%b expected=%b", k, got_seq[k], exp_seq[k]);
      else passed++;
    end
    checks++;
    if (ovr_seen !== 0) $display("FAIL simul_overrun got=%0d expected=0", ovr_seen); else passed++;
  endtask

  task automatic test_overrun();
    int multi, b2b, dropped;
    bit seen;
    logic [2:0] prev;
    do_reset();
    multi = 0; b2b = 0; dropped = 0; seen = 1'b0; prev = '0;
    for (int c = 0; c < 80; c++) begin
      pb = (c < 60) ? 3'b111 : 3'b000;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== {m_lvl[m], m_pulse[m], m_ovr[m]})
          $display("FAIL overrun_model inst%0d cyc=%0d got=%b expected=%b", m, cyc, obs[m], {m_lvl[m], m_pulse[m], m_ovr[m]});
        else passed++;
      end
      if (!$onehot0(if_b.BtnPulse)) multi++;
      if (prev != 3'b000 && if_b.BtnPulse != 3'b000) b2b++;
      prev = if_b.BtnPulse;
      if (seen && if_b.Overrun !== 1'b1) dropped++;
      if (if_b.Overrun === 1'b1) seen = 1'b1;
    end
    checks++;
    if (if_b.Overrun !== 1'b1) $display("FAIL overrun_set got=%b expected=1", if_b.Overrun); else passed++;
    checks++;
    if (dropped !== 0) $display("FAIL overrun_sticky got=%0d expected=0", dropped); else passed++;
    checks++;
    if (multi !== 0) $display("FAIL overrun_multihot got=%0d expected=0", multi); else passed++;
    checks++;
    if (b2b !== 0) $display("FAIL overrun_backtoback got=%0d expected=0", b2b); else passed++;
  endtask

  task automatic test_reset_midop();
    int e, pulses, first;
    do_reset();
    e = cyc + 1; pulses = 0; first = -1;
    for (int c = 0; c < 30; c++) begin
      pb = 3'b001;
      RESET = (c == 6);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== {m_lvl[m], m_pulse[m], m_ovr[m]})
          $display("FAIL midreset_model inst%0d cyc=%0d got=%b expected=%b", m, cyc, obs[m], {m_lvl[m], m_pulse[m], m_ovr[m]});
        else passed++;
      end
      if (if_a.BtnPulse[0]) begin
        pulses++;
        if (first < 0) first = cyc - e;
      end
    end
    RESET = 1'b0;
    checks++;
    if (pulses !== 1) $display("FAIL midreset_count got=%0d expected=1", pulses); else passed++;
    checks++;
    if (first !== 13) $display("FAIL midreset_latency got=%0d expected=13", first); else passed++;
  endtask

  task automatic test_random();
    int idx;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, 2));
        pb[idx] = ~pb[idx];
      end
      RESET = ($urandom_range(0, 149) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== {m_lvl[m], m_pulse[m], m_ovr[m]})
          $display("FAIL random_model inst%0d cyc=%0d got=%b expected=%b", m, cyc, obs[m], {m_lvl[m], m_pulse[m], m_ovr[m]});
        else passed++;
      end
    end
    RESET = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    cyc = 0;
    RESET = 1'b1;
    pb = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_overrun();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the three raw board push-buttons (Right, Up, Down) before they reach the grid tracker that consumes `PushButton`. It synchronizes, debounces, and adds auto-repeat. It emits at most one single-cycle move pulse per clock, so the tracker's rising-edge detector never sees bounce or loses simultaneous presses. The block sits between the board pins and the tracker's `PushButton[2:0]` input.

## Interface
- `NBTN`, 3: number of button channels; bit 0 Right, 1 Up, 2 Down.
- `DEBOUNCE_CYCLES`, 4: consecutive cycles the synchronized input must differ from the debounced level before the level flips. Must be ≥1; use ~1_000_000 on board.
- `REPEAT_DELAY`, 20: cycles a button must stay held after its press pulse before the first repeat. 0 disables auto-repeat.
- `REPEAT_RATE`, 8: cycles between subsequent repeats. Must be ≥2.
- `CLK`  in  1  system clock; the only clock.
- `RESET`  in  1  synchronous, active-high reset, sampled on the `CLK` rising edge.
- `PushButton`  in  NBTN  raw asynchronous button levels, 1 = pressed.
- `BtnLevel`  out  NBTN  debounced, registered button levels.
- `BtnPulse`  out  NBTN  registered move pulses, at most one bit high per cycle. Feeds the tracker's `PushButton`.
- `Overrun`  out  1  sticky flag: an event merged into an already-pending event on the same channel.

## Operation
- Reset: synchronizers, `BtnLevel`, debounce counters, repeat counters, the pending register, `BtnPulse` and `Overrun` all go to 0.
- Synchronizer: each channel passes through two flops; `s[i]` is the second-stage output.
- Debounce, per channel: counter `dc[i]`, 32 bits.
  - If `s[i] == BtnLevel[i]`, `dc[i]` ← 0.
  - Otherwise, if `dc[i] == DEBOUNCE_CYCLES-1`, `BtnLevel[i]` ← `s[i]` and `dc[i]` ← 0.
  - Otherwise `dc[i]` increments.
  - A single-cycle glitch shorter than `DEBOUNCE_CYCLES` never changes the level.
- Press event: a 0→1 transition of `BtnLevel[i]` sets `pend[i]` on the same edge. A 1→0 transition produces no event.
- Auto-repeat, per channel: counter `rc[i]`, 32 bits.
  - On a press, `rc[i]` ← 0.
  - While `BtnLevel[i]` is high, `rc[i]` increments each cycle.
  - A repeat event sets `pend[i]` when `rc[i]` reaches `REPEAT_DELAY`, then every `REPEAT_RATE` cycles after that; `rc[i]` reloads to `REPEAT_DELAY-REPEAT_RATE` on each repeat.
  - On release, `rc[i]` ← 0.
  - With `REPEAT_DELAY == 0`, no repeats occur.
- Arbiter, each cycle:
  - If `BtnPulse` was nonzero in the previous cycle, `BtnPulse` ← 0. This is a mandatory gap cycle, so every pulse is a clean rising edge for the downstream edge detector.
  - Otherwise the lowest-index set `pend` bit `k` is emitted: `BtnPulse` ← one-hot(`k`) and `pend[k]` ← 0.
  - With no pending bits, `BtnPulse` ← 0.
- Merge: an event arriving for channel `i` while `pend[i]` is already 1 (and not being cleared this cycle) is dropped and sets `Overrun` ← 1. `Overrun` stays set until reset.
- An event arriving in the same cycle that `pend[i]` is being emitted sets `pend[i]` again; it is not dropped.

## Timing
- Press latency: a `PushButton[i]` rise, held stable, first lands in sync stage 1 on edge E. Then:
  - `s[i]` rises at E+1.
  - `BtnLevel[i]` rises at E+1+`DEBOUNCE_CYCLES`.
  - `BtnPulse[i]` is high for exactly one cycle at E+2+`DEBOUNCE_CYCLES`, provided the arbiter is idle.
- With defaults, the press pulse appears 6 edges after E.
- Release latency: `BtnLevel` falls `DEBOUNCE_CYCLES`+1 edges after the input first samples low.
- Pulses are spaced at least 2 cycles apart, across all channels combined.
- Simultaneous presses are emitted in the order Right, Up, Down, on cycles P, P+2 and P+4.
- `RESET` asserted mid-operation clears everything on the next edge; a pulse in flight is truncated. A button still held after reset is re-debounced and produces a fresh press pulse.

## Test plan
- Reset: hold `RESET` for 3 cycles with buttons toggling -> all outputs 0 throughout and on the first cycle after release.
- Single press: `PushButton[0]` high for 10 cycles, then low -> exactly one `BtnPulse[0]` high cycle, 6 edges after first sample. `BtnLevel[0]` high for 10 cycles. No repeat.
- Bounce: `PushButton[1]` toggles every cycle for 12 cycles, then settles high -> no pulse during bouncing. Exactly one `BtnPulse[1]` once the input has been stable for 4+2 cycles.
- Auto-repeat: hold `PushButton[2]` for 60 cycles -> press pulse at P, repeats at P+20, P+28, P+36, P+44, P+52. No pulse after release.
- Simultaneous: all three buttons rise on the same edge -> `BtnPulse` = 001, 000, 010, 000, 100 on consecutive cycles. `Overrun` stays 0.
- Overrun: `REPEAT_RATE`=2 with all three held past `REPEAT_DELAY` -> arbiter saturates and `Overrun` goes to 1 and stays set. `BtnPulse` is never multi-hot and never high on back-to-back cycles.
